// File: rtl/gpu_fetch_pkg.sv
// Shared types and tag layout for the GPU pixel fetcher.
// Optional feature macro: GPU_PIXEL_FETCH_HSCROLL_EN (fine horizontal scroll).
package gpu_fetch_pkg;

  typedef enum logic [1:0] {
    BPP_1 = 2'd0,
    BPP_2 = 2'd1,
    BPP_4 = 2'd2,
    BPP_8 = 2'd3
  } bpp_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_ACTIVE    = 2'd2
  } fetch_state_t;

  localparam int unsigned TAG_VALID  = 31;
  localparam int unsigned TAG_BPP_HI = 30;
  localparam int unsigned TAG_BPP_LO = 29;
  localparam int unsigned TAG_PIX_W  = 4;

  // Index of the last pixel held in one 16-bit word for a given depth.
  function automatic logic [3:0] pix_last(input bpp_t b);
    case (b)
      BPP_1:   return 4'd15;
      BPP_2:   return 4'd7;
      BPP_4:   return 4'd3;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/gpu_pixel_fetcher_if.sv
// Read-port bus between the pixel fetcher and the multiplexed GPU RAM.
interface gpu_pixel_fetcher_if #(
  parameter int unsigned ADDR_W = 20
);
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_cmd;
  logic [15:0]       rd_data;
  logic [31:0]       rd_cmd_ret;

  modport master (
    output rd_addr,
    output rd_cmd,
    input  rd_data,
    input  rd_cmd_ret
  );

  modport slave (
    input  rd_addr,
    input  rd_cmd,
    output rd_data,
    output rd_cmd_ret
  );
endinterface

// File: rtl/gpu_pixel_unpack.sv
// Decodes one pixel from a returned RAM word using only the echoed tag.
module gpu_pixel_unpack
  import gpu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] rd_data,
  input  logic [31:0] rd_cmd_ret,
  output logic [7:0]  pixel_out,
  output logic        pixel_valid
);

  logic [1:0] bpp_c;
  logic [3:0] p_c;
  logic [7:0] end_c;
  logic [3:0] lo_c;
  logic [7:0] shifted_c;
  logic [7:0] pix_c;
  logic       unused_tag_bits;

  assign unused_tag_bits = ^rd_cmd_ret[TAG_BPP_LO-1:TAG_PIX_W];

  // Select the MSB-first field of width 1<<bpp at pixel index p.
  always_comb begin
    bpp_c     = rd_cmd_ret[TAG_BPP_HI:TAG_BPP_LO];
    p_c       = rd_cmd_ret[TAG_PIX_W-1:0];
    end_c     = 8'(({4'd0, p_c} + 8'd1) << bpp_c);
    lo_c      = 4'(8'd16 - end_c);
    shifted_c = 8'(rd_data >> lo_c);
    pix_c     = 8'd0;
    case (bpp_c)
      2'd0:    pix_c = {7'd0, shifted_c[0]};
      2'd1:    pix_c = {6'd0, shifted_c[1:0]};
      2'd2:    pix_c = {4'd0, shifted_c[3:0]};
      default: pix_c = shifted_c;
    endcase
  end

  // Register the decoded pixel once per pixel period; invalid tags give zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out   <= 8'd0;
      pixel_valid <= 1'b0;
    end else if (tick) begin
      pixel_valid <= rd_cmd_ret[TAG_VALID];
      pixel_out   <= rd_cmd_ret[TAG_VALID] ? pix_c : 8'd0;
    end
  end

endmodule

// File: rtl/gpu_pixel_fetcher.sv
// Requester-side client for one read port of the multiplexed GPU RAM.
// Optional feature macro: GPU_PIXEL_FETCH_HSCROLL_EN adds fine_scroll[3:0].
module gpu_pixel_fetcher
  import gpu_fetch_pkg::*;
#(
  parameter int unsigned PC_MAX  = 4,
  parameter int unsigned PC_TICK = 1,
  parameter int unsigned ADDR_W  = 20
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        pc_ena_in,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              hde,
  input  logic              vde,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       line_stride,
  input  logic [1:0]        bpp_mode,
`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
  input  logic [3:0]        fine_scroll,
`endif
  gpu_pixel_fetcher_if.master ram,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        p;
  bpp_t              bpp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [31:0]       rd_cmd_q;

  logic              tick_c;
  logic [3:0]        p_init_c;

  assign tick_c = (pc_ena_in == 4'(PC_TICK)) && (PC_TICK <= PC_MAX);

`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
  assign p_init_c = fine_scroll & pix_last(bpp_t'(bpp_mode));
`else
  assign p_init_c = 4'd0;
`endif

  assign ram.rd_addr = rd_addr_q;
  assign ram.rd_cmd  = rd_cmd_q;

  // Frame/line sequencing and request generation, advancing only on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      line_addr <= '0;
      word_addr <= '0;
      p         <= 4'd0;
      bpp_q     <= BPP_1;
      rd_addr_q <= '0;
      rd_cmd_q  <= 32'd0;
    end else if (tick_c) begin
      if (frame_start) begin
        line_addr <= base_addr;
      end
      case (state)
        ST_IDLE: begin
          rd_cmd_q[TAG_VALID] <= 1'b0;
          if (frame_start) begin
            state <= ST_WAIT_LINE;
          end
        end
        ST_WAIT_LINE: begin
          if (line_start && vde) begin
            // A coincident frame_start must win over the stale line address.
            word_addr <= frame_start ? base_addr : line_addr;
            p         <= p_init_c;
            bpp_q     <= bpp_t'(bpp_mode);
            state     <= ST_ACTIVE;
          end else if (!vde && !frame_start) begin
            state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (hde) begin
            rd_addr_q <= word_addr;
            rd_cmd_q  <= {1'b1, bpp_q, 25'd0, p};
            if (p == pix_last(bpp_q)) begin
              p         <= 4'd0;
              word_addr <= word_addr + ADDR_W'(1);
            end else begin
              p <= p + 4'd1;
            end
          end else begin
            if (!frame_start) begin
              line_addr <= line_addr + ADDR_W'(line_stride);
            end
            rd_cmd_q[TAG_VALID] <= 1'b0;
            state               <= ST_WAIT_LINE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  gpu_pixel_unpack u_unpack (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick_c),
    .rd_data     (ram.rd_data),
    .rd_cmd_ret  (ram.rd_cmd_ret),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid)
  );

endmodule

// File: tb/tb_gpu_pixel_fetcher.sv
// Directed bench for gpu_pixel_fetcher (GPU_PIXEL_FETCH_HSCROLL_EN adds a scroll scenario).
module tb_gpu_pixel_fetcher;

  logic        clk;
  logic        reset;
  logic [3:0]  pc_ena_in;
  logic        frame_start;
  logic        line_start;
  logic        hde;
  logic        vde;
  logic [19:0] base_addr;
  logic [15:0] line_stride;
  logic [1:0]  bpp_mode;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
  logic [3:0]  fine_scroll;
`endif

  int n_checks;
  int n_fail;

  gpu_pixel_fetcher_if #(.ADDR_W(20)) bus ();

  gpu_pixel_fetcher dut (
    .clk         (clk),
    .reset       (reset),
    .pc_ena_in   (pc_ena_in),
    .frame_start (frame_start),
    .line_start  (line_start),
    .hde         (hde),
    .vde         (vde),
    .base_addr   (base_addr),
    .line_stride (line_stride),
    .bpp_mode    (bpp_mode),
`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
    .fine_scroll (fine_scroll),
`endif
    .ram         (bus.master),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // One pixel period: phases 0..4, inputs change on the falling edge.
  task automatic pix();
    for (int ph = 0; ph <= 4; ph++) begin
      @(negedge clk);
      pc_ena_in = 4'(ph);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; hde = 1'b0; vde = 1'b0;
    bus.rd_data = 16'd0; bus.rd_cmd_ret = 32'd0;
    pix();
    reset = 1'b0;
  endtask

  // frame_start pixel followed by a line_start pixel; leaves hde high.
  task automatic open_line(input logic [19:0] base, input logic [1:0] bpp);
    base_addr = base; bpp_mode = bpp; vde = 1'b1;
    frame_start = 1'b1; pix(); frame_start = 1'b0;
    line_start = 1'b1;  pix(); line_start = 1'b0;
    hde = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.rd_addr !== 20'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h expected %h", bus.rd_addr, 20'h0); end
    n_checks++; if (bus.rd_cmd !== 32'h0) begin n_fail++; $display("FAIL reset_rd_cmd: got %h expected %h", bus.rd_cmd, 32'h0); end
    n_checks++; if (pixel_out !== 8'h0) begin n_fail++; $display("FAIL reset_pixel_out: got %h expected %h", pixel_out, 8'h0); end
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_valid: got %b expected %b", pixel_valid, 1'b0); end
  endtask

  // 40-pixel 1bpp line then the start of the next line one stride later.
  task automatic test_line_1bpp();
    logic [19:0] exp_a;
    logic [31:0] exp_c;
    do_reset();
    line_stride = 16'd40;
    open_line(20'h01000, 2'd0);
    for (int i = 0; i < 40; i++) begin
      pix();
      exp_a = 20'h01000 + 20'(i / 16);
      exp_c = 32'h8000_0000 | 32'(i % 16);
      n_checks++; if (bus.rd_addr !== exp_a) begin n_fail++; $display("FAIL line_addr[%0d]: got %h expected %h", i, bus.rd_addr, exp_a); end
      n_checks++; if (bus.rd_cmd !== exp_c) begin n_fail++; $display("FAIL line_tag[%0d]: got %h expected %h", i, bus.rd_cmd, exp_c); end
    end
    hde = 1'b0; pix();
    n_checks++; if (bus.rd_cmd[31] !== 1'b0) begin n_fail++; $display("FAIL line_end_valid: got %b expected %b", bus.rd_cmd[31], 1'b0); end
    line_start = 1'b1; pix(); line_start = 1'b0;
    hde = 1'b1; pix();
    n_checks++; if (bus.rd_addr !== 20'h01028) begin n_fail++; $display("FAIL next_line_addr: got %h expected %h", bus.rd_addr, 20'h01028); end
    n_checks++; if (bus.rd_cmd !== 32'h8000_0000) begin n_fail++; $display("FAIL next_line_tag: got %h expected %h", bus.rd_cmd, 32'h8000_0000); end
    hde = 1'b0; vde = 1'b0; pix();
  endtask

  task automatic test_decode();
    do_reset();
    bus.rd_data = 16'hA5C3;
    bus.rd_cmd_ret = 32'hC000_0001; pix();
    n_checks++; if (pixel_out !== 8'h05) begin n_fail++; $display("FAIL dec_4bpp_p1: got %h expected %h", pixel_out, 8'h05); end
    n_checks++; if (pixel_valid !== 1'b1) begin n_fail++; $display("FAIL dec_4bpp_valid: got %b expected %b", pixel_valid, 1'b1); end
    bus.rd_cmd_ret = 32'hE000_0001; pix();
    n_checks++; if (pixel_out !== 8'hC3) begin n_fail++; $display("FAIL dec_8bpp_p1: got %h expected %h", pixel_out, 8'hC3); end
    bus.rd_cmd_ret = 32'h8000_0000; pix();
    n_checks++; if (pixel_out !== 8'h01) begin n_fail++; $display("FAIL dec_1bpp_p0: got %h expected %h", pixel_out, 8'h01); end
    bus.rd_cmd_ret = 32'h8000_0001; pix();
    n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL dec_1bpp_p1: got %h expected %h", pixel_out, 8'h00); end
    bus.rd_cmd_ret = 32'hA000_0007; pix();
    n_checks++; if (pixel_out !== 8'h03) begin n_fail++; $display("FAIL dec_2bpp_p7: got %h expected %h", pixel_out, 8'h03); end
    bus.rd_cmd_ret = 32'h6000_0001; pix();
    n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL dec_invalid_pix: got %h expected %h", pixel_out, 8'h00); end
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL dec_invalid_valid: got %b expected %b", pixel_valid, 1'b0); end
  endtask

  task automatic test_wrap();
    logic [19:0] exp_a [4];
    logic [31:0] exp_c;
    exp_a[0] = 20'hFFFFF; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000; exp_a[3] = 20'h00000;
    do_reset();
    open_line(20'hFFFFF, 2'd3);
    for (int i = 0; i < 4; i++) begin
      pix();
      exp_c = 32'hE000_0000 | 32'(i % 2);
      n_checks++; if (bus.rd_addr !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, bus.rd_addr, exp_a[i]); end
      n_checks++; if (bus.rd_cmd !== exp_c) begin n_fail++; $display("FAIL wrap_tag[%0d]: got %h expected %h", i, bus.rd_cmd, exp_c); end
    end
    hde = 1'b0; vde = 1'b0; pix();
  endtask

  // frame_start and line_start together must use the freshly latched base.
  task automatic test_simultaneous();
    do_reset();
    line_stride = 16'd40; bpp_mode = 2'd0; vde = 1'b1;
    base_addr = 20'h01000; frame_start = 1'b1; pix();
    base_addr = 20'h02000; line_start = 1'b1; pix();
    frame_start = 1'b0; line_start = 1'b0;
    hde = 1'b1; pix();
    n_checks++; if (bus.rd_addr !== 20'h02000) begin n_fail++; $display("FAIL simul_addr: got %h expected %h", bus.rd_addr, 20'h02000); end
    hde = 1'b0; pix();
    line_start = 1'b1; pix(); line_start = 1'b0;
    hde = 1'b1; pix();
    n_checks++; if (bus.rd_addr !== 20'h02028) begin n_fail++; $display("FAIL simul_next_line: got %h expected %h", bus.rd_addr, 20'h02028); end
    hde = 1'b0; vde = 1'b0; pix();
  endtask

  task automatic test_midline_reset();
    do_reset();
    open_line(20'h01000, 2'd0);
    bus.rd_data = 16'h8000; bus.rd_cmd_ret = 32'h8000_0000;
    for (int i = 0; i < 5; i++) pix();
    n_checks++; if (pixel_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected %b", pixel_valid, 1'b1); end
    n_checks++; if (bus.rd_addr !== 20'h01000) begin n_fail++; $display("FAIL pre_reset_addr: got %h expected %h", bus.rd_addr, 20'h01000); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_checks++; if (bus.rd_cmd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cmd: got %h expected %h", bus.rd_cmd, 32'h0); end
    n_checks++; if (bus.rd_addr !== 20'h0) begin n_fail++; $display("FAIL mid_reset_addr: got %h expected %h", bus.rd_addr, 20'h0); end
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected %b", pixel_valid, 1'b0); end
    n_checks++; if (pixel_out !== 8'h0) begin n_fail++; $display("FAIL mid_reset_pix: got %h expected %h", pixel_out, 8'h0); end
    bus.rd_cmd_ret = 32'd0;
    line_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix();
      n_checks++; if (bus.rd_cmd !== 32'h0) begin n_fail++; $display("FAIL idle_no_req[%0d]: got %h expected %h", i, bus.rd_cmd, 32'h0); end
    end
    line_start = 1'b0; hde = 1'b0;
    open_line(20'h01000, 2'd0);
    pix();
    n_checks++; if (bus.rd_cmd !== 32'h8000_0000) begin n_fail++; $display("FAIL resume_tag: got %h expected %h", bus.rd_cmd, 32'h8000_0000); end
    n_checks++; if (bus.rd_addr !== 20'h01000) begin n_fail++; $display("FAIL resume_addr: got %h expected %h", bus.rd_addr, 20'h01000); end
    hde = 1'b0; vde = 1'b0; pix();
  endtask

`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
  task automatic test_hscroll();
    logic [19:0] exp_a [4];
    logic [3:0]  exp_p [4];
    logic [31:0] exp_c;
    exp_a[0] = 20'h03000; exp_a[1] = 20'h03000; exp_a[2] = 20'h03000; exp_a[3] = 20'h03001;
    exp_p[0] = 4'd5; exp_p[1] = 4'd6; exp_p[2] = 4'd7; exp_p[3] = 4'd0;
    do_reset();
    fine_scroll = 4'd13;
    open_line(20'h03000, 2'd1);
    for (int i = 0; i < 4; i++) begin
      pix();
      exp_c = 32'hA000_0000 | 32'(exp_p[i]);
      n_checks++; if (bus.rd_addr !== exp_a[i]) begin n_fail++; $display("FAIL hscroll_addr[%0d]: got %h expected %h", i, bus.rd_addr, exp_a[i]); end
      n_checks++; if (bus.rd_cmd !== exp_c) begin n_fail++; $display("FAIL hscroll_tag[%0d]: got %h expected %h", i, bus.rd_cmd, exp_c); end
    end
    hde = 1'b0; vde = 1'b0; fine_scroll = 4'd0; pix();
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    pc_ena_in = 4'd0; reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    hde = 1'b0; vde = 1'b0; base_addr = 20'd0; line_stride = 16'd0; bpp_mode = 2'd0;
    bus.rd_data = 16'd0; bus.rd_cmd_ret = 32'd0;
`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
    fine_scroll = 4'd0;
`endif
    test_reset();
    test_line_1bpp();
    test_decode();
    test_wrap();
    test_simultaneous();
    test_midline_reset();
`ifdef GPU_PIXEL_FETCH_HSCROLL_EN
    test_hscroll();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
